// File: rtl/cp0_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cp0_pkg                                                   |
// | Purpose  : Shared CP0 definitions: register addresses, except_type   |
// |            encodings, ExcCode values, Status/Cause bit positions,    |
// |            plus helpers that classify an incoming except_type.       |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package cp0_pkg;

   // CP0 register numbers (MTC0/MFC0 rd field)
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   // except_type encodings delivered by the pipeline
   localparam logic [31:0] EXC_NONE = 32'h0;
   localparam logic [31:0] EXC_INT  = 32'h1;
   localparam logic [31:0] EXC_ADEL = 32'h4;
   localparam logic [31:0] EXC_ADES = 32'h5;
   localparam logic [31:0] EXC_SYS  = 32'h8;
   localparam logic [31:0] EXC_BP   = 32'h9;
   localparam logic [31:0] EXC_RI   = 32'ha;
   localparam logic [31:0] EXC_OV   = 32'hc;
   localparam logic [31:0] EXC_ERET = 32'he;

   // ExcCode values written into Cause[6:2]
   localparam logic [4:0] EXCCODE_INT  = 5'd0;
   localparam logic [4:0] EXCCODE_ADEL = 5'd4;
   localparam logic [4:0] EXCCODE_ADES = 5'd5;
   localparam logic [4:0] EXCCODE_SYS  = 5'd8;
   localparam logic [4:0] EXCCODE_BP   = 5'd9;
   localparam logic [4:0] EXCCODE_RI   = 5'd10;
   localparam logic [4:0] EXCCODE_OV   = 5'd12;

   // Status bit positions
   localparam int STATUS_IE    = 0;
   localparam int STATUS_EXL   = 1;
   localparam int STATUS_IM_LO = 8;
   localparam int STATUS_IM_HI = 15;

   // Cause bit positions
   localparam int CAUSE_EXC_LO   = 2;
   localparam int CAUSE_EXC_HI   = 6;
   localparam int CAUSE_IP_LO    = 8;
   localparam int CAUSE_IP_HW_LO = 10;
   localparam int CAUSE_IP_HI    = 15;
   localparam int CAUSE_BD       = 31;

   // Software-writable bits
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

   typedef enum logic [1:0] {
      EXC_CLASS_NONE = 2'd0,   // no event, or an unrecognised encoding
      EXC_CLASS_TAKE = 2'd1,   // a real exception/interrupt is taken
      EXC_CLASS_ERET = 2'd2    // return from exception
   } exc_class_e;

   function automatic exc_class_e classify_exc(input logic [31:0] et);
      case (et)
         EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
         EXC_BP, EXC_RI, EXC_OV:  return EXC_CLASS_TAKE;
         EXC_ERET:                return EXC_CLASS_ERET;
         default:                 return EXC_CLASS_NONE;
      endcase
   endfunction

   // Interrupts report ExcCode 0; every other taken code equals its encoding.
   function automatic logic [4:0] exc_code(input logic [31:0] et);
      return (et == EXC_INT) ? EXCCODE_INT : et[4:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cp0_timer                                                 |
// | Purpose  : CP0 Count/Compare pair. Count advances every second clock |
// |            via a tick toggle; timer_int latches one cycle after a    |
// |            Count==Compare match and holds until Compare is written.  |
// | Ports    : clk, rst          - clock, async active-high reset        |
// |            count_we          - load Count (also restarts the tick)   |
// |            compare_we        - load Compare (clears timer_int)       |
// |            wdata[31:0]       - write data                            |
// |            count, compare    - register contents                     |
// |            timer_int         - latched timer interrupt               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cp0_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_int
);

   logic        tick_reg,      tick_nxt;
   logic [31:0] count_reg,     count_nxt;
   logic [31:0] compare_reg,   compare_nxt;
   logic        timer_int_reg, timer_int_nxt;

   always_comb begin
      tick_nxt      = ~tick_reg;
      count_nxt     = tick_reg ? count_reg + 32'd1 : count_reg;
      compare_nxt   = compare_reg;
      timer_int_nxt = timer_int_reg;

      // A software load of Count realigns the half-rate tick.
      if (count_we) begin
         count_nxt = wdata;
         tick_nxt  = 1'b0;
      end

      // Compare == 0 means the timer is disarmed.
      if ((compare_reg != 32'd0) && (count_reg == compare_reg))
         timer_int_nxt = 1'b1;

      // Writing Compare acknowledges the interrupt; it wins over a match.
      if (compare_we) begin
         compare_nxt   = wdata;
         timer_int_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tick_reg <= 1'b0;
      else     tick_reg <= tick_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_reg <= 32'd0;
      else     count_reg <= count_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) compare_reg <= 32'd0;
      else     compare_reg <= compare_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) timer_int_reg <= 1'b0;
      else     timer_int_reg <= timer_int_nxt;
   end

   assign count     = count_reg;
   assign compare   = compare_reg;
   assign timer_int = timer_int_reg;

endmodule
`default_nettype wire

// File: rtl/cp0_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cp0_regfile                                               |
// | Purpose  : MIPS-style CP0 register file: BadVAddr, Count, Compare,   |
// |            Status, Cause, EPC. Handles MTC0/MFC0, exception entry,   |
// |            ERET, interrupt sampling and the pending-interrupt flag.  |
// | Ports    : clk, rst                 - clock, async active-high reset |
// |            we_i/waddr_i/wdata_i     - MTC0 write port                |
// |            raddr_i/rdata_o          - MFC0 read port (combinational) |
// |            int_i[5:0]               - hardware interrupts HW5..HW0   |
// |            except_type_i, current_inst_addr_i, is_in_delayslot_i,   |
// |            bad_addr_i               - exception information          |
// |            status_o..compare_o      - register contents              |
// |            timer_int_o, int_o       - timer / pending interrupt      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cp0_regfile #(
   parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_i,
   output logic [31:0] rdata_o,
   input  logic [5:0]  int_i,
   input  logic [31:0] except_type_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   input  logic [31:0] bad_addr_i,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] badvaddr_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        timer_int_o,
   output logic        int_o
);

   import cp0_pkg::*;

   logic [31:0] status_reg,   status_nxt;
   logic [31:0] cause_reg,    cause_nxt;
   logic [31:0] epc_reg,      epc_nxt;
   logic [31:0] badvaddr_reg, badvaddr_nxt;
   logic [31:0] count_val;
   logic [31:0] compare_val;
   logic        timer_int;
   logic        mtc0;
   exc_class_e  exc_class;

   // Any non-zero except_type (even an unrecognised one) blocks MTC0.
   assign mtc0      = we_i & (except_type_i == EXC_NONE);
   assign exc_class = classify_exc(except_type_i);

   cp0_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (mtc0 && (waddr_i == CP0_COUNT)),
      .compare_we (mtc0 && (waddr_i == CP0_COMPARE)),
      .wdata      (wdata_i),
      .count      (count_val),
      .compare    (compare_val),
      .timer_int  (timer_int)
   );

   always_comb begin
      status_nxt   = status_reg;
      cause_nxt    = cause_reg;
      epc_nxt      = epc_reg;
      badvaddr_nxt = badvaddr_reg;

      if (mtc0) begin
         case (waddr_i)
            CP0_STATUS:   status_nxt   = (status_reg & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
            CP0_CAUSE:    cause_nxt    = (cause_reg  & ~CAUSE_WMASK)  | (wdata_i & CAUSE_WMASK);
            CP0_EPC:      epc_nxt      = wdata_i;
            CP0_BADVADDR: badvaddr_nxt = wdata_i;
            default:      ;
         endcase
      end

      case (exc_class)
         EXC_CLASS_TAKE: begin
            // A nested exception (EXL already set) must not clobber the
            // return context of the outer one.
            if (!status_reg[STATUS_EXL]) begin
               epc_nxt                = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                          : current_inst_addr_i;
               cause_nxt[CAUSE_BD]    = is_in_delayslot_i;
               status_nxt[STATUS_EXL] = 1'b1;
            end
            cause_nxt[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code(except_type_i);
            if ((except_type_i == EXC_ADEL) || (except_type_i == EXC_ADES))
               badvaddr_nxt = bad_addr_i;
         end
         EXC_CLASS_ERET: status_nxt[STATUS_EXL] = 1'b0;
         default:        ;
      endcase

      // Hardware IP bits track the pins every cycle; the timer shares HW5.
      cause_nxt[CAUSE_IP_HI:CAUSE_IP_HW_LO] = {int_i[5] | timer_int, int_i[4:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) status_reg <= RESET_STATUS;
      else     status_reg <= status_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cause_reg <= 32'd0;
      else     cause_reg <= cause_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) epc_reg <= 32'd0;
      else     epc_reg <= epc_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) badvaddr_reg <= 32'd0;
      else     badvaddr_reg <= badvaddr_nxt;
   end

   // MFC0 sees the current register state; a same-cycle MTC0 is not bypassed.
   always_comb begin
      case (raddr_i)
         CP0_BADVADDR: rdata_o = badvaddr_reg;
         CP0_COUNT:    rdata_o = count_val;
         CP0_COMPARE:  rdata_o = compare_val;
         CP0_STATUS:   rdata_o = status_reg;
         CP0_CAUSE:    rdata_o = cause_reg;
         CP0_EPC:      rdata_o = epc_reg;
         default:      rdata_o = 32'd0;
      endcase
   end

   assign int_o = status_reg[STATUS_IE] & ~status_reg[STATUS_EXL] &
                  (|(cause_reg[CAUSE_IP_HI:CAUSE_IP_LO] & status_reg[STATUS_IM_HI:STATUS_IM_LO]));

   assign status_o    = status_reg;
   assign cause_o     = cause_reg;
   assign epc_o       = epc_reg;
   assign badvaddr_o  = badvaddr_reg;
   assign count_o     = count_val;
   assign compare_o   = compare_val;
   assign timer_int_o = timer_int;

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_cp0_regfile                                            |
// | Purpose  : Self-checking bench for cp0_regfile: directed scenarios   |
// |            plus randomized traffic against a behavioural model.      |
// | Ports    : none                                                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_cp0_regfile;

   localparam logic [31:0] RST_STATUS = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we_i = 1'b0;
   logic [4:0]  waddr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [4:0]  raddr_i = '0;
   logic [31:0] rdata_o;
   logic [5:0]  int_i = '0;
   logic [31:0] except_type_i = '0;
   logic [31:0] current_inst_addr_i = '0;
   logic        is_in_delayslot_i = 1'b0;
   logic [31:0] bad_addr_i = '0;
   logic [31:0] status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
   logic        timer_int_o, int_o;

   always #5 clk = ~clk;

   cp0_regfile #(.RESET_STATUS(RST_STATUS)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .we_i                (we_i),
      .waddr_i             (waddr_i),
      .wdata_i             (wdata_i),
      .raddr_i             (raddr_i),
      .rdata_o             (rdata_o),
      .int_i               (int_i),
      .except_type_i       (except_type_i),
      .current_inst_addr_i (current_inst_addr_i),
      .is_in_delayslot_i   (is_in_delayslot_i),
      .bad_addr_i          (bad_addr_i),
      .status_o            (status_o),
      .cause_o             (cause_o),
      .epc_o               (epc_o),
      .badvaddr_o          (badvaddr_o),
      .count_o             (count_o),
      .compare_o           (compare_o),
      .timer_int_o         (timer_int_o),
      .int_o               (int_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Count is modelled as "value last loaded + half the clocks since then".
   logic [31:0] m_status, m_cause, m_epc, m_badv, m_compare, m_base, m_elapsed;
   logic        m_timer;

   function automatic logic [31:0] m_count();
      return m_base + (m_elapsed >> 1);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return m_badv;
         5'd9:    return m_count();
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_int();
      return m_status[0] & ~m_status[1] & (|(m_cause[15:8] & m_status[15:8]));
   endfunction

   task automatic m_reset();
      m_status = RST_STATUS; m_cause = 0; m_epc = 0; m_badv = 0;
      m_compare = 0; m_base = 0; m_elapsed = 0; m_timer = 1'b0;
   endtask

   task automatic check_all();
      check_eq("status",   status_o,   m_status);
      check_eq("cause",    cause_o,    m_cause);
      check_eq("epc",      epc_o,      m_epc);
      check_eq("badvaddr", badvaddr_o, m_badv);
      check_eq("count",    count_o,    m_count());
      check_eq("compare",  compare_o,  m_compare);
      check_eq("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
      check_eq("int_o",    {31'd0, int_o}, {31'd0, m_int()});
   endtask

   // One clock: check combinational outputs, predict, clock, check state.
   task automatic step();
      logic [31:0] n_status, n_cause, n_epc, n_badv, n_compare, n_base, n_elapsed;
      logic        n_timer, taken, wr;
      logic [31:0] et;
      #1;
      check_eq("rdata", rdata_o, m_read(raddr_i));
      check_eq("int_o_comb", {31'd0, int_o}, {31'd0, m_int()});
      et = except_type_i;
      n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_badv = m_badv;
      n_compare = m_compare; n_base = m_base; n_elapsed = m_elapsed + 1; n_timer = m_timer;
      taken = et inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc};
      wr = we_i && (et == 0);
      if (wr) begin
         case (waddr_i)
            5'd8:  n_badv = wdata_i;
            5'd9:  begin n_base = wdata_i; n_elapsed = 0; end
            5'd11: n_compare = wdata_i;
            5'd12: n_status = {m_status[31:16], wdata_i[15:8], m_status[7:2], wdata_i[1:0]};
            5'd13: n_cause = {m_cause[31:10], wdata_i[9:8], m_cause[7:0]};
            5'd14: n_epc = wdata_i;
            default: ;
         endcase
      end
      if (taken) begin
         if (!m_status[1]) begin
            n_epc = is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i;
            n_cause[31] = is_in_delayslot_i;
            n_status[1] = 1'b1;
         end
         n_cause[6:2] = (et == 1) ? 5'd0 : et[4:0];
         if (et == 4 || et == 5) n_badv = bad_addr_i;
      end
      if (et == 32'he) n_status[1] = 1'b0;
      if (m_compare != 0 && m_count() == m_compare) n_timer = 1'b1;
      if (wr && waddr_i == 5'd11) n_timer = 1'b0;
      n_cause[15:10] = {int_i[5] | m_timer, int_i[4:0]};
      @(posedge clk);
      #1;
      m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_badv = n_badv;
      m_compare = n_compare; m_base = n_base; m_elapsed = n_elapsed; m_timer = n_timer;
      check_all();
   endtask

   task automatic idle();
      we_i = 0; waddr_i = 0; wdata_i = 0; except_type_i = 0;
      is_in_delayslot_i = 0; bad_addr_i = 0; int_i = 0;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      idle(); we_i = 1; waddr_i = a; wdata_i = d; step(); idle();
   endtask

   task automatic raise(input logic [31:0] et, input logic [31:0] pc, input logic ds, input logic [31:0] ba);
      idle(); except_type_i = et; current_inst_addr_i = pc; is_in_delayslot_i = ds;
      bad_addr_i = ba; step(); idle();
   endtask

   logic [31:0] et_tab [12] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha,
                                32'hc, 32'he, 32'h3, 32'h7, 32'hff, 32'h2};
   logic [4:0]  ad_tab [8]  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd20};

   initial begin
      int n;
      logic [31:0] epc_keep;
      m_reset();
      #12;
      check_all();
      @(negedge clk); rst = 0;

      // syscall, not in delay slot
      raise(32'h8, 32'hBFC0_0100, 1'b0, 32'h0);
      check_eq("sys_epc", epc_o, 32'hBFC0_0100);
      check_eq("sys_exccode", {27'd0, cause_o[6:2]}, 32'd8);
      check_eq("sys_exl", {31'd0, status_o[1]}, 32'd1);
      check_eq("sys_bd", {31'd0, cause_o[31]}, 32'd0);
      raise(32'he, 32'h0, 1'b0, 32'h0);

      // AdEL in a delay slot
      raise(32'h4, 32'h8000_0008, 1'b1, 32'h0000_0003);
      check_eq("adel_epc", epc_o, 32'h8000_0004);
      check_eq("adel_bd", {31'd0, cause_o[31]}, 32'd1);
      check_eq("adel_badv", badvaddr_o, 32'h3);

      // nested overflow while EXL=1, then ERET
      raise(32'hc, 32'h1234_5678, 1'b0, 32'h0);
      check_eq("nest_exccode", {27'd0, cause_o[6:2]}, 32'd12);
      check_eq("nest_epc", epc_o, 32'h8000_0004);
      raise(32'he, 32'h0, 1'b0, 32'h0);
      check_eq("eret_exl", {31'd0, status_o[1]}, 32'd0);

      // MTC0 Status concurrent with a breakpoint is dropped
      mtc0(5'd12, 32'h0000_AB01);
      idle(); we_i = 1; waddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF; except_type_i = 32'h9;
      step(); idle();
      check_eq("bp_status", status_o, 32'h0040_AB03);
      raise(32'he, 32'h0, 1'b0, 32'h0);

      // timer interrupt path
      mtc0(5'd12, 32'h0000_8001);
      mtc0(5'd11, 32'd10);
      mtc0(5'd9, 32'd0);
      n = 0;
      while (!timer_int_o && n < 60) begin step(); n++; end
      check_eq("timer_latency", n, 32'd21);
      step();
      check_eq("timer_int_o_hi", {31'd0, int_o}, 32'd1);
      mtc0(5'd11, 32'd1000);
      check_eq("timer_clr", {31'd0, timer_int_o}, 32'd0);
      step();
      check_eq("int_clr", {31'd0, int_o}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         idle();
         raddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : ad_tab[$urandom_range(0, 5)];
         int_i = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         if ($urandom_range(0, 5) == 0) except_type_i = et_tab[$urandom_range(0, 11)];
         current_inst_addr_i = $urandom & 32'hFFFF_FFFC;
         is_in_delayslot_i = 1'($urandom);
         bad_addr_i = $urandom;
         if ($urandom_range(0, 2) == 0) begin
            we_i = 1;
            waddr_i = ad_tab[$urandom_range(0, 7)];
            wdata_i = $urandom;
            if (waddr_i == 5'd11) wdata_i = m_count() + $urandom_range(0, 6);
            if (waddr_i == 5'd9 && $urandom_range(0, 3) == 0) wdata_i = 32'hFFFF_FFFE;
            if (waddr_i == 5'd12) wdata_i = wdata_i | 32'h1;
         end
         step();
      end

      // asynchronous reset mid-count
      idle();
      mtc0(5'd9, 32'h0000_0100);
      step(); step(); step();
      #2 rst = 1;
      #1;
      m_reset();
      check_eq("rst_count", count_o, 32'd0);
      check_eq("rst_status", status_o, RST_STATUS);
      check_eq("rst_timer", {31'd0, timer_int_o}, 32'd0);
      check_eq("rst_int", {31'd0, int_o}, 32'd0);
      check_all();
      @(posedge clk);
      @(negedge clk); rst = 0;
      step();
      check_eq("restart_cnt0", count_o, 32'd0);
      step();
      check_eq("restart_cnt1", count_o, 32'd1);
      step(); step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have parameter RESET_STATUS, default 32'h0040_0000, the Status value loaded on reset (BEV=1).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports we_i  in  1 (MTC0 strobe); waddr_i  in  5; wdata_i  in  32.
REQ-005 SHALL have ports raddr_i  in  5 (MFC0 address) and rdata_o  out  32 (MFC0 data).
REQ-006 SHALL have port int_i  in  6  hardware interrupt lines HW5..HW0.
REQ-007 SHALL have ports except_type_i  in  32 (encoded exception); current_inst_addr_i  in  32; is_in_delayslot_i  in  1; bad_addr_i  in  32.
REQ-008 SHALL have ports status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o  out  32  each (register contents).
REQ-009 SHALL have ports timer_int_o  out  1 and int_o  out  1 (pending enabled interrupt, to the exception translator).

Function
REQ-010 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); reads of other addresses return 0.
REQ-011 SHALL drive rdata_o combinationally from current register state, with no bypass of a same-cycle write.
REQ-012 SHALL decode except_type_i: 0 none; 1 interrupt (ExcCode 0); 4 AdEL; 5 AdES; 8 Sys; 9 Bp; 'ha RI; 'hc Ov (ExcCode = except_type_i[4:0]); 'he ERET; any other value is ignored.
REQ-013 SHALL ignore an MTC0 write in any cycle where except_type_i != 0.
REQ-014 SHALL restrict MTC0 writes to: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC, BadVAddr, Count, and Compare in full.
REQ-015 SHALL, on an exception with Status.EXL=0, set EPC to current_inst_addr_i-4 if is_in_delayslot_i, else to current_inst_addr_i; set Cause.BD to is_in_delayslot_i; set EXL to 1; and set Cause.ExcCode [6:2].
REQ-016 SHALL, on an exception with EXL=1, update Cause.ExcCode only, leaving EPC and BD unchanged.
REQ-017 SHALL load BadVAddr from bad_addr_i on AdEL or AdES only.
REQ-018 SHALL, on ERET, clear EXL and leave all other registers unchanged.
REQ-019 SHALL sample Cause.IP[15:10] from int_i every cycle, and SHALL force IP[15] to int_i[5] | timer_int_o.
REQ-020 SHALL increment Count every second clock through an internal tick toggle, wrapping from 32'hFFFF_FFFF to 0.
REQ-021 SHALL, on an MTC0 write to Count, load Count with wdata_i and clear the tick toggle.
REQ-022 SHALL set timer_int_o one cycle after Count == Compare while Compare != 0, and SHALL hold it until an MTC0 write to Compare.
REQ-023 SHALL drive int_o combinationally as Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]).
REQ-024 SHALL give an exception in the same cycle as a Count==Compare match both effects; they are independent.

Reset
REQ-025 SHALL, on rst, clear all registers except Status, which loads RESET_STATUS.
REQ-026 SHALL, on rst, force timer_int_o=0, int_o=0 and tick=0, asynchronously, including mid-count.
REQ-027 SHALL act on the first rising clk after rst deasserts.

Structure
REQ-028 SHALL take from shared package cp0_pkg: CP0 register addresses, except_type encodings, ExcCode constants, and Status/Cause bit positions.
REQ-029 SHALL implement Count/Compare/tick/timer_int as sub-module cp0_timer.
REQ-030 SHALL be expressible as one combinational next-state block plus one registered block per register; no FSM beyond the tick toggle.

Verification
REQ-031 SHALL cover: except_type_i=8, pc=32'hBFC0_0100, not in delay slot -> next cycle EPC=32'hBFC0_0100, ExcCode=8, EXL=1, BD=0.
REQ-032 SHALL cover: except_type_i=4, in delay slot, pc=32'h8000_0008, bad_addr_i=32'h0000_0003 -> EPC=32'h8000_0004, BD=1, BadVAddr=32'h3.
REQ-033 SHALL cover: EXL=1 then except_type_i='hc -> ExcCode=12 while EPC is unchanged; then 'he -> EXL=0.
REQ-034 SHALL cover: MTC0 Compare=10 and Count=0 -> timer_int_o rises about 21 cycles later; with Status=32'h0000_8001, int_o=1; a Compare write clears both.
REQ-035 SHALL cover: we_i=1, waddr=12 concurrent with except_type_i=9 -> Status keeps IE/IM values and EXL=1.
REQ-036 SHALL cover: rst asserted mid-count -> all outputs reset immediately; after release, Count restarts from 0.
